// File: rtl/sudoku_defs.sv
`default_nettype none
// sudoku_defs: state encodings and BCD digit constants shared by the score timer.
package sudoku_defs;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WON  = 2'b10,
    ST_LOST = 2'b11
  } state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
endpackage
`default_nettype wire

// File: rtl/bcd_sub_sat.sv
`default_nettype none
// bcd_sub_sat: combinational ripple-borrow packed-BCD subtractor, a-b saturating at 0.
module bcd_sub_sat
  import sudoku_defs::*;
#(
  parameter int NDIGITS = 3
) (
  input  logic [NDIGITS*BCD_DIGIT_W-1:0] a,
  input  logic [NDIGITS*BCD_DIGIT_W-1:0] b,
  output logic [NDIGITS*BCD_DIGIT_W-1:0] diff,
  output logic                           zero
);
  logic [NDIGITS*BCD_DIGIT_W-1:0] raw;
  logic                           borrow;
  logic [BCD_DIGIT_W:0]           t;

  always_comb begin
    raw    = '0;
    borrow = 1'b0;
    t      = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      t = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
        - {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
        - {{BCD_DIGIT_W{1'b0}}, borrow};
      // A negative digit wraps modulo 16; adding 10 restores the decimal digit.
      if (t[BCD_DIGIT_W]) begin
        raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_MAX_DIGIT + 1);
        borrow = 1'b1;
      end else begin
        raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = t[BCD_DIGIT_W-1:0];
        borrow = 1'b0;
      end
    end
  end

  assign diff = borrow ? '0 : raw;
  assign zero = (diff == '0);
endmodule
`default_nettype wire

// File: rtl/bcd_score_timer.sv
`default_nettype none
// bcd_score_timer: N-digit BCD game countdown with pause, penalty, warning and best score.
module bcd_score_timer
  import sudoku_defs::*;
#(
  parameter int                          NDIGITS     = 3,
  parameter logic [NDIGITS*4-1:0]        START_BCD   = 'h999,
  parameter logic [NDIGITS*4-1:0]        BEST_INIT   = 'h002,
  parameter logic [NDIGITS*4-1:0]        PENALTY_BCD = 'h010,
  parameter logic [NDIGITS*4-1:0]        WARN_BCD    = 'h030
) (
  input  logic                  clk_high,
  input  logic                  clr_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  penalty,
  input  logic                  win,
  output logic [NDIGITS*4-1:0]  time_bcd,
  output logic [NDIGITS*4-1:0]  best_bcd,
  output logic [1:0]            state,
  output logic                  lose_flag,
  output logic                  warn,
  output logic                  new_best
);
  localparam int W = NDIGITS * BCD_DIGIT_W;

  state_t         state_q, state_d;
  logic [W-1:0]   time_q, time_d;
  logic [W-1:0]   best_q, best_d;
  logic           new_best_q, new_best_d;
  logic [W-1:0]   tick_diff, pen_diff;
  logic           tick_zero, pen_zero;

  bcd_sub_sat #(.NDIGITS(NDIGITS)) u_sub_tick (
    .a    (time_q),
    .b    (W'(1)),
    .diff (tick_diff),
    .zero (tick_zero)
  );

  bcd_sub_sat #(.NDIGITS(NDIGITS)) u_sub_pen (
    .a    (time_q),
    .b    (PENALTY_BCD),
    .diff (pen_diff),
    .zero (pen_zero)
  );

  always_ff @(posedge clk_high or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      time_q     <= START_BCD;
      best_q     <= BEST_INIT;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    best_d     = best_q;
    new_best_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (start) begin
          time_d = START_BCD;
        end else if (win) begin
          state_d = ST_WON;
          // Legal BCD orders the same as unsigned binary.
          if (time_q > best_q) begin
            best_d     = time_q;
            new_best_d = 1'b1;
          end
        end else if (penalty) begin
          time_d = pen_diff;
          if (pen_zero) state_d = ST_LOST;
        end else if (tick && !pause) begin
          time_d = tick_diff;
          if (tick_zero) state_d = ST_LOST;
        end
      end
      ST_IDLE, ST_WON, ST_LOST: begin
        if (start) begin
          state_d = ST_RUN;
          time_d  = START_BCD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign time_bcd  = time_q;
  assign best_bcd  = best_q;
  assign state     = state_q;
  assign lose_flag = (state_q == ST_LOST);
  assign warn      = (state_q == ST_RUN) && (time_q <= WARN_BCD);
  assign new_best  = new_best_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_score_timer.sv
`default_nettype none
// tb_bcd_score_timer: directed self-checking bench for the BCD score timer.
module tb_bcd_score_timer;
  logic        clk_high = 1'b0;
  logic        clk_en   = 1'b0;
  logic        clr_n, tick, start, pause, penalty, win;
  logic [11:0] time_bcd, best_bcd;
  logic [1:0]  state;
  logic        lose_flag, warn, new_best;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_score_timer dut (
    .clk_high  (clk_high),
    .clr_n     (clr_n),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .penalty   (penalty),
    .win       (win),
    .time_bcd  (time_bcd),
    .best_bcd  (best_bcd),
    .state     (state),
    .lose_flag (lose_flag),
    .warn      (warn),
    .new_best  (new_best)
  );

  initial begin
    wait (clk_en);
    forever #5 clk_high = ~clk_high;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_high);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clr_n = 1'b1; tick = 0; start = 0; pause = 0; penalty = 0; win = 0;
    #1 clr_n = 1'b0;
    #1;
    check("rst_time",  32'(time_bcd),  32'h999);
    check("rst_best",  32'(best_bcd),  32'h002);
    check("rst_state", 32'(state),     32'd0);
    check("rst_lose",  32'(lose_flag), 32'd0);
    check("rst_warn",  32'(warn),      32'd0);
    check("rst_nb",    32'(new_best),  32'd0);

    clk_en = 1'b1;
    repeat (2) @(negedge clk_high);
    clr_n = 1'b1;
    #1;
    tick = 1; penalty = 1; win = 1;
    step();
    tick = 0; penalty = 0; win = 0;
    check("idle_time",  32'(time_bcd), 32'h999);
    check("idle_state", 32'(state),    32'd0);

    do_start();
    check("start_state", 32'(state),    32'd1);
    check("start_time",  32'(time_bcd), 32'h999);
    ticks(10);
    check("t989", 32'(time_bcd), 32'h989);
    ticks(889);
    check("t100", 32'(time_bcd), 32'h100);
    ticks(1);
    check("t099", 32'(time_bcd), 32'h099);
    pause = 1'b1;
    ticks(5);
    pause = 1'b0;
    check("pause_hold", 32'(time_bcd), 32'h099);
    ticks(68);
    check("t031", 32'(time_bcd), 32'h031);
    check("warn_031", 32'(warn), 32'd0);
    ticks(1);
    check("t030", 32'(time_bcd), 32'h030);
    check("warn_030", 32'(warn), 32'd1);
    ticks(29);
    check("t001", 32'(time_bcd), 32'h001);
    check("t001_state", 32'(state), 32'd1);
    ticks(1);
    check("t000", 32'(time_bcd), 32'h000);
    check("lost_state", 32'(state), 32'd3);
    check("lost_flag", 32'(lose_flag), 32'd1);
    check("lost_warn", 32'(warn), 32'd0);
    ticks(3);
    check("lost_hold", 32'(time_bcd), 32'h000);
    check("lost_hold_state", 32'(state), 32'd3);

    do_start();
    ticks(994);
    check("t005", 32'(time_bcd), 32'h005);
    penalty = 1'b1;
    step();
    penalty = 1'b0;
    check("pen_sat", 32'(time_bcd), 32'h000);
    check("pen_lost", 32'(state), 32'd3);
    do_start();
    ticks(499);
    check("t500", 32'(time_bcd), 32'h500);
    penalty = 1'b1; tick = 1'b1;
    step();
    penalty = 1'b0; tick = 1'b0;
    check("pen_tick", 32'(time_bcd), 32'h490);
    check("pen_tick_state", 32'(state), 32'd1);

    do_start();
    ticks(149);
    win = 1'b1;
    step();
    win = 1'b0;
    check("win1_state", 32'(state), 32'd2);
    check("win1_best",  32'(best_bcd), 32'h850);
    check("win1_nb",    32'(new_best), 32'd1);
    step();
    check("win1_nb_drop", 32'(new_best), 32'd0);
    check("win1_frozen",  32'(time_bcd), 32'h850);
    do_start();
    ticks(299);
    win = 1'b1;
    step();
    win = 1'b0;
    check("win2_time", 32'(time_bcd), 32'h700);
    check("win2_best", 32'(best_bcd), 32'h850);
    check("win2_nb",   32'(new_best), 32'd0);
    do_start();
    ticks(149);
    win = 1'b1;
    step();
    win = 1'b0;
    check("win3_state", 32'(state), 32'd2);
    check("win3_best",  32'(best_bcd), 32'h850);
    check("win3_nb",    32'(new_best), 32'd0);

    do_start();
    ticks(387);
    check("t612", 32'(time_bcd), 32'h612);
    #2 clr_n = 1'b0;
    #1;
    check("arst_time",  32'(time_bcd), 32'h999);
    check("arst_best",  32'(best_bcd), 32'h002);
    check("arst_state", 32'(state),    32'd0);
    @(negedge clk_high);
    clr_n = 1'b1;
    start = 1'b1; win = 1'b1;
    step();
    start = 1'b0; win = 1'b0;
    check("sw_state", 32'(state),    32'd1);
    check("sw_time",  32'(time_bcd), 32'h999);
    check("sw_best",  32'(best_bcd), 32'h002);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
